// File: rtl/spi_pkg.sv
// Shared definitions for the SPI MISO receive path.
//   DATA_WIDTH_DEF : default word length
//   state_t        : receive FSM state encoding
package spi_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : spi_pkg

// File: rtl/spi_rx_hold.sv
// One-entry holding register between the deserializer and the host.
// Ports:
//   clk, rst             : clock, async active-low reset
//   load_c               : a completed word is offered this cycle
//   load_data            : the completed word
//   rx_ready             : host accepts rx_data when rx_valid & rx_ready
//   clr_ovr              : clear the sticky overrun flag
//   rx_data/rx_valid     : held word and its valid flag
//   overrun              : sticky, a completed word was dropped
module spi_rx_hold
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_c,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  rx_ready,
    input  logic                  clr_ovr,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  overrun
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ovr_q, ovr_d;
    logic                  accept;
    logic                  ovr_set;

    // Load when the slot is empty or being emptied this cycle; otherwise drop and flag.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_set = 1'b0;
        accept  = valid_q & rx_ready;

        if (load_c) begin
            if (!valid_q || rx_ready) begin
                data_d  = load_data;
                valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end

        // A new overrun beats a coincident clear.
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign overrun  = ovr_q;

endmodule : spi_rx_hold

// File: rtl/spi_miso_rx.sv
// Master-side SPI receive deserializer: samples MISO on sclk_rise, MSB first,
// and hands each completed word to a one-entry valid/ready holding register.
// Ports:
//   clk, rst            : clock, async active-low reset
//   start, abort        : begin a frame (IDLE only) / discard partial frame
//   sclk_rise, miso     : sample strobe and serial data
//   rx_data, rx_valid   : held word and valid flag
//   rx_ready            : host accept
//   busy, frame_done    : in SHIFT/DONE, and the DONE cycle itself
//   overrun, clr_ovr    : sticky dropped-word flag and its clear
module spi_miso_rx
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  sclk_rise,
    input  logic                  miso,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun,
    input  logic                  clr_ovr
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  load_c;

    // Next-state, counter and shift register.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        load_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_SHIFT;
                    count_d = '0;
                    shift_d = '0;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], miso};
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(DATA_WIDTH - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                count_d = '0;
                load_c  = !abort;
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    // Pure state decodes; frame_done is gated by abort since an abort in DONE discards the word.
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE) && !abort;

    spi_rx_hold #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load_c    (load_c),
        .load_data (shift_q),
        .rx_ready  (rx_ready),
        .clr_ovr   (clr_ovr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .overrun   (overrun)
    );

endmodule : spi_miso_rx

// File: tb/tb_spi_miso_rx.sv
// Self-checking bench for spi_miso_rx: a table of frames with expected holding
// register state, followed by hand-written abort, reset and edge-case sequences.
module tb_spi_miso_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, sclk_rise, miso, rx_ready, clr_ovr;
    logic [7:0] rx_data;
    logic       rx_valid, busy, frame_done, overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_seen = 0;

    spi_miso_rx #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .sclk_rise  (sclk_rise),
        .miso       (miso),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_done) fd_seen++;

    typedef struct {
        logic [7:0] data;        // frame content sent MSB first
        logic       rdy_done;    // rx_ready asserted in the DONE cycle
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_ovr;
        logic       accept;      // perform a host accept afterwards
        logic       clr;         // pulse clr_ovr afterwards
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // n strobes spaced 4 cycles, MSB first from d[7]
    task automatic strobes(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            miso      = d[7-i];
            sclk_rise = 1'b1;
            tick();
            sclk_rise = 1'b0;
            if (i != n - 1) begin
                tick(); tick(); tick();
            end
        end
    endtask

    // Full frame; leaves the bench one cycle after DONE (rx_* visible).
    task automatic send_frame(input logic [7:0] d, input logic rdy_done, input logic abort_done);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        strobes(d, 8);
        abort    = abort_done;
        rx_ready = rdy_done;
        #1;
        check("frame_done_in_done", 32'(frame_done), 32'(!abort_done));
        tick();
        abort    = 1'b0;
        rx_ready = 1'b0;
        check("frame_done_low_after", 32'(frame_done), 32'd0);
        check("busy_idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b0; start = 0; abort = 0; sclk_rise = 0; miso = 0; rx_ready = 0; clr_ovr = 0;

        vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hC3, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0};  // accepts C3 in DONE
        vecs[4] = '{8'h22, 1'b0, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1};  // dropped: overrun
        vecs[5] = '{8'h55, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'hAA, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0};  // accept coincident with DONE

        #12;
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b1;
        tick();

        // Strobes in IDLE are ignored.
        strobes(8'hFF, 2);
        tick();
        check("idle_strobe_busy", 32'(busy), 32'd0);
        check("idle_strobe_valid", 32'(rx_valid), 32'd0);

        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].data, vecs[v].rdy_done, 1'b0);
            check($sformatf("v%0d_data", v), 32'(rx_data), 32'(vecs[v].exp_data));
            check($sformatf("v%0d_valid", v), 32'(rx_valid), 32'(vecs[v].exp_valid));
            check($sformatf("v%0d_ovr", v), 32'(overrun), 32'(vecs[v].exp_ovr));
            tick(); tick();
            check($sformatf("v%0d_stable", v), 32'(rx_data), 32'(vecs[v].exp_data));
            if (vecs[v].clr) begin
                clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
                check($sformatf("v%0d_clr_ovr", v), 32'(overrun), 32'd0);
            end
            if (vecs[v].accept) begin
                rx_ready = 1'b1; tick(); rx_ready = 1'b0;
                check($sformatf("v%0d_accept", v), 32'(rx_valid), 32'd0);
            end
        end

        // Abort after 4 strobes: holding register untouched, no frame_done.
        send_frame(8'h99, 1'b0, 1'b0);
        fd_seen = 0;
        start = 1'b1; tick(); start = 1'b0;
        strobes(8'h0F, 4);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        strobes(8'h0F, 4);
        tick(); tick();
        check("abort_no_fd", 32'(fd_seen), 32'd0);
        check("abort_valid_kept", 32'(rx_valid), 32'd1);
        check("abort_data_kept", 32'(rx_data), 32'h99);
        rx_ready = 1'b1; tick(); rx_ready = 1'b0;
        send_frame(8'hF0, 1'b0, 1'b0);
        check("fresh_after_abort", 32'(rx_data), 32'hF0);
        check("fresh_valid", 32'(rx_valid), 32'd1);

        // Abort in DONE discards the word without frame_done.
        send_frame(8'h3A, 1'b1, 1'b1);
        check("abort_done_valid", 32'(rx_valid), 32'd0);
        check("abort_done_data", 32'(rx_data), 32'hF0);
        check("abort_done_ovr", 32'(overrun), 32'd0);

        // Start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        check("start_abort_idle", 32'(busy), 32'd0);

        // Overrun set beats coincident clr_ovr.
        send_frame(8'h12, 1'b0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        strobes(8'h34, 8);
        clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
        check("set_beats_clr", 32'(overrun), 32'd1);
        check("set_beats_clr_data", 32'(rx_data), 32'h12);

        // Async reset mid-frame, away from the clock edge.
        start = 1'b1; tick(); start = 1'b0;
        strobes(8'hFF, 5);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 32'(rx_valid), 32'd0);
        check("arst_data", 32'(rx_data), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ovr", 32'(overrun), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        strobes(8'hFF, 8);
        tick(); tick();
        check("post_rst_valid", 32'(rx_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spi_miso_rx

// File: doc/spi_miso_rx.md
Name: spi_miso_rx

Overview:
- Master-side SPI receive deserializer. It consumes the MISO bit stream produced by the slave shift-out register.
- MISO is sampled on a one-cycle `sclk_rise` strobe from the SPI clock generator. The slave shifts on the falling edge, so data is stable at the rise.
- Bits are assembled MSB-first into a DATA_WIDTH word.
- The word is handed to the host through a one-entry holding register with a valid/ready handshake and a sticky overrun flag.

Parameters:
- DATA_WIDTH, 8, word length in bits; must be >= 2.
- CNT_W, $clog2(DATA_WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a frame. Honoured only in IDLE.
- abort  in  1  synchronous; discards any partial frame and returns to IDLE.
- sclk_rise  in  1  one-cycle strobe marking the SCLK rising edge (MISO sample point).
- miso  in  1  serial data from slave, already synchronised.
- rx_data  out  DATA_WIDTH  holding-register contents.
- rx_valid  out  1  holding register contains an unread word.
- rx_ready  in  1  host accepts rx_data when rx_valid & rx_ready.
- busy  out  1  high in SHIFT or DONE.
- frame_done  out  1  high for exactly the DONE cycle.
- overrun  out  1  sticky; a completed word was dropped.
- clr_ovr  in  1  synchronous clear of overrun.

Behaviour:
- Reset values (asynchronous on rst low): state=IDLE, shift reg=0, count=0, rx_data=0, rx_valid=0, overrun=0. Hence busy=0 and frame_done=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 -> SHIFT; count<=0, shift reg<=0.
  - sclk_rise is ignored in IDLE.
- SHIFT, on each sclk_rise:
  - shift reg <= {shift reg[DATA_WIDTH-2:0], miso}; count<=count+1.
  - On the strobe where count==DATA_WIDTH-1 -> DONE.
  - Cycles without sclk_rise hold all state.
- DONE (one cycle):
  - frame_done=1; count<=0; next state IDLE.
  - Load rule: if rx_valid=0, or rx_ready=1 this cycle, then rx_data<=shift reg and rx_valid<=1.
  - Otherwise the new word is dropped, rx_data is unchanged and overrun<=1.
- Latency: 8th sclk_rise sampled in cycle N -> frame_done in N+1 -> rx_valid/rx_data visible from N+2.
- Handshake:
  - rx_valid falls the cycle after rx_valid & rx_ready, unless a DONE load occurs in the same cycle.
  - A simultaneous accept and DONE load gives rx_valid=1 with the new data and no overrun.
  - rx_data is stable while rx_valid=1 and not accepted.
- start while busy: ignored, no error.
- start and abort in the same IDLE cycle: abort wins; stay in IDLE.
- abort:
  - In SHIFT: -> IDLE, count<=0, no load, no frame_done.
  - In DONE: abort wins; the word is discarded and frame_done is still 0.
  - Holding register and overrun are unaffected.
- Overrun clearing:
  - clr_ovr clears overrun.
  - If clr_ovr coincides with a new overrun event, set wins.
- Reset mid-frame: immediate return to reset values; a pending rx_valid word is lost.
- The bit counter never exceeds DATA_WIDTH-1 in SHIFT; no wrap-around path exists.

Decomposition:
- Shared package spi_pkg holds:
  - FSM state encoding localparams (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2).
  - Default DATA_WIDTH.
- One sub-module is natural: spi_rx_hold, the one-entry holding register with valid/ready and overrun logic.
- The FSM, counter and shift register stay in spi_miso_rx.

Test Plan:
- Basic frame: start, then 8 sclk_rise strobes spaced 4 cycles with miso=1,0,1,0,0,1,0,1 -> frame_done one cycle after 8th strobe; rx_data=8'hA5, rx_valid=1 from the next cycle; overrun=0.
- Back-to-back, host ready: frames 8'h3C then 8'hC3 with rx_ready=1 -> two rx_valid handshakes delivering 3C then C3; overrun=0.
- Overrun: frame 8'h11 not accepted (rx_ready=0), then frame 8'h22 -> rx_data stays 8'h11, overrun=1. clr_ovr pulse -> overrun=0.
- Accept coincident with DONE: rx_valid=1 holding 8'h55; rx_ready=1 exactly in the DONE cycle of frame 8'hAA -> rx_data=8'hAA, rx_valid=1, overrun=0.
- Abort: abort after 4 strobes -> state IDLE, no frame_done, rx_valid unchanged. Fresh frame 8'hF0 -> rx_data=8'hF0.
- Async reset: rst low after 5 strobes with rx_valid=1 -> all outputs at reset values without waiting for clk. Strobes after release without start -> rx_valid stays 0.
